// File: rtl/tc_pkg.sv
// tc_pkg: shared state encoding, register offsets and CTRL field positions for timer_counter
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam int EN      = 0;
    localparam int MODE_LO = 1;
    localparam int MODE_HI = 2;
    localparam int IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only the exact reload code restarts; the unused codes behave as one-shot.
    function automatic logic is_reload(input logic [1:0] m);
        return m == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: word-register bus between the CPU bridge and one timer instance
interface timer_counter_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);

endinterface

// File: rtl/tc_prescaler.sv
// tc_prescaler: divides the count step by P+1; only built when TC_PRESCALE_EN is defined
`ifdef TC_PRESCALE_EN
module tc_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] p,
    output logic         tick
);

    logic [W-1:0] cnt;

    // >= keeps the divider from running a full wrap if P is lowered mid-count
    assign tick = cnt >= p;

    // Counts 0..P while running; restarts from 0 on every reload.
    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot/auto-reload interrupt; TC_PRESCALE_EN adds a prescaler
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0,
    parameter int          PRESCALE_W   = 4
) (
    input logic            clk,
    input logic            reset,
    timer_counter_if.slave bus
);

    tc_state_e   state, state_nxt;
    logic [31:0] preset, count, count_nxt, ctrl_rd;
    logic [1:0]  mode;
    logic        en, im, irq_flag;
    logic        ctrl_wr, flag_set, flag_clr, en_clr, tick;

    assign ctrl_wr = bus.we && bus.addr == CTRL_OFF;

`ifdef TC_PRESCALE_EN
    logic [PRESCALE_W-1:0] p;

    // Prescale field lives beside the other CTRL bits and is written with them.
    always_ff @(posedge clk) begin
        if (reset)
            p <= '0;
        else if (ctrl_wr)
            p <= bus.wdata[4 +: PRESCALE_W];
    end

    tc_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state == LOAD),
        .run   (state == CNT),
        .p     (p),
        .tick  (tick)
    );

    assign ctrl_rd = 32'({p, im, mode, en});
`else
    assign tick    = 1'b1;
    assign ctrl_rd = {{(28 - PRESCALE_W){1'b0}}, {PRESCALE_W{1'b0}}, im, mode, en};
`endif

    // Next state, next COUNT and the flag/enable side effects of each state.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_set  = 1'b0;
        flag_clr  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            IDLE: if (en) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (count > 32'd1) begin
                        count_nxt = count - 32'd1;
                    end else begin
                        count_nxt = '0;
                        flag_set  = 1'b1;
                        state_nxt = INT;
                    end
                end
            end
            INT: begin
                if (is_reload(mode)) begin
                    flag_clr  = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Register file and FSM state; a CPU CTRL write overrides the one-shot enable clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            preset   <= RESET_PRESET;
            count    <= '0;
            en       <= 1'b0;
            mode     <= MODE_ONESHOT;
            im       <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (bus.we && bus.addr == PRESET_OFF)
                preset <= bus.wdata;
            if (ctrl_wr) begin
                en   <= bus.wdata[EN];
                mode <= bus.wdata[MODE_HI:MODE_LO];
                im   <= bus.wdata[IM];
            end else if (en_clr) begin
                en <= 1'b0;
            end
            irq_flag <= ctrl_wr ? 1'b0 : flag_set ? 1'b1 : flag_clr ? 1'b0 : irq_flag;
        end
    end

    assign bus.rdata = bus.addr == CTRL_OFF   ? ctrl_rd :
                       bus.addr == PRESET_OFF ? preset  :
                       bus.addr == COUNT_OFF  ? count   : 32'h0;

    assign bus.irq = im & irq_flag;

endmodule
